// File: rtl/osc_pkt_pkg.sv
// Shared types and constants for the oscilloscope packet path: sequencer states and packet framing.
package osc_pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        CSUM
    } seq_state_t;

    localparam logic [7:0] PKT_HEADER    = 8'd115;
    localparam int         PKT_NUM_BYTES = 13;
    localparam int         PKT_SEL_W     = 4;

endpackage

// File: rtl/gap_timer.sv
// Inter-packet gap down-counter: load arms GAP_CYCLES, done is high in the last counted cycle.
// Counts only while run is high; saturates at zero so it is clear whenever the gap is left.
module gap_timer #(
    parameter int GAP_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic done
);
    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(GAP_CYCLES);
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loaded value N is seen in the first gap cycle, so value 1 marks the Nth.
    assign done = (cnt == CW'(1));

endmodule

// File: rtl/packet_tx_sequencer.sv
// Walks select 0..NUM_BYTES-1, hands each byte to UART TX (>=2 clocks/byte, tx_valid/tx_data held until tx_ready), then idles GAP_CYCLES.
// Optional macro PKT_CHECKSUM_EN appends a running-XOR byte via the CSUM state; pkt_done then pulses on that byte.
module packet_tx_sequencer
    import osc_pkt_pkg::*;
#(
    parameter int NUM_BYTES  = PKT_NUM_BYTES,
    parameter int SEL_W      = PKT_SEL_W,
    parameter int GAP_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pkt_req,
    input  logic [7:0]       sel_data,
    output logic [SEL_W-1:0] select,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             pkt_done
);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_BYTES - 1);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    seq_state_t state;
    logic       last_accept;
    logic       gap_done;

`ifdef PKT_CHECKSUM_EN
    logic [7:0] csum;
    assign last_accept = (state == CSUM) && tx_ready;
`else
    assign last_accept = (state == SEND) && tx_ready && (select == LAST_SEL);
`endif

    gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk  (clk),
        .reset(reset),
        .load (last_accept),
        .run  (state == GAP),
        .done (gap_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            select   <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            pkt_done <= 1'b0;
`ifdef PKT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            pkt_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pkt_req) begin
                        state  <= LOAD;
                        select <= '0;
                        busy   <= 1'b1;
`ifdef PKT_CHECKSUM_EN
                        csum   <= '0;
`endif
                    end
                end
                LOAD: begin
                    tx_data  <= sel_data;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
`ifdef PKT_CHECKSUM_EN
                        csum     <= csum ^ tx_data;
`endif
                        if (select != LAST_SEL) begin
                            select <= select + 1'b1;
                            state  <= LOAD;
                        end else begin
`ifdef PKT_CHECKSUM_EN
                            // Checksum byte follows immediately; select parks on the last index.
                            tx_data  <= csum ^ tx_data;
                            tx_valid <= 1'b1;
                            state    <= CSUM;
`else
                            pkt_done <= 1'b1;
                            select   <= '0;
                            busy     <= HAS_GAP;
                            state    <= HAS_GAP ? GAP : IDLE;
`endif
                        end
                    end
                end
`ifdef PKT_CHECKSUM_EN
                CSUM: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        pkt_done <= 1'b1;
                        select   <= '0;
                        busy     <= HAS_GAP;
                        state    <= HAS_GAP ? GAP : IDLE;
                    end
                end
`endif
                GAP: begin
                    if (gap_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
